// File: rtl/leaf_pkg.sv
// Shared packet layout, credit limits and packet builder for the leaf transmit path.
package leaf_pkg;

  localparam int PAYLOAD_W = 32;
  localparam int ADDR_W    = 7;
  localparam int PORT_W    = 4;
  localparam int LEAF_W    = 5;
  localparam int BRAM_W    = 7;

  localparam int ADDR_LSB  = PAYLOAD_W;
  localparam int PORT_LSB  = ADDR_LSB + ADDR_W;
  localparam int LEAF_LSB  = PORT_LSB + PORT_W;
  localparam int VALID_BIT = LEAF_LSB + LEAF_W;
  localparam int PKT_W     = VALID_BIT + 1;

  localparam int CREDIT_W = BRAM_W + 1;
  localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(1 << BRAM_W);

  typedef struct packed {
    logic                 valid;
    logic [LEAF_W-1:0]    leaf;
    logic [PORT_W-1:0]    port;
    logic [ADDR_W-1:0]    addr;
    logic [PAYLOAD_W-1:0] payload;
  } packet_t;

  function automatic logic [PKT_W-1:0] make_packet(
    input logic [LEAF_W-1:0]    leaf,
    input logic [PORT_W-1:0]    port,
    input logic [ADDR_W-1:0]    addr,
    input logic [PAYLOAD_W-1:0] payload
  );
    logic [PKT_W-1:0] p;
    p = '0;
    p[VALID_BIT]                = 1'b1;
    p[LEAF_LSB +: LEAF_W]       = leaf;
    p[PORT_LSB +: PORT_W]       = port;
    p[ADDR_LSB +: ADDR_W]       = addr;
    p[0 +: PAYLOAD_W]           = payload;
    return p;
  endfunction

endpackage

// File: rtl/leaf_rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer wins; pointer moves past it on accept.
module leaf_rr_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 accept,
  output logic [NUM_PORTS-1:0] grant,
  output logic [IDX_W-1:0]     grant_idx
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W:0]   cand;
  logic [IDX_W-1:0] cand_idx;
  logic             found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    cand_idx  = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_PORTS)) cand = cand - (IDX_W+1)'(NUM_PORTS);
      cand_idx = cand[IDX_W-1:0];
      if (!found && req[cand_idx]) begin
        found           = 1'b1;
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (accept && found) begin
      ptr_q <= (grant_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/leaf_tx_packetizer.sv
// Leaf transmit side: arbitrates user output ports, stamps dest/addr and drives one packet per cycle
// toward the BFT, gated by per-port credits that mirror the remote receive buffer.
module leaf_tx_packetizer #(
  parameter int PACKET_BITS        = 49,
  parameter int PAYLOAD_BITS       = 32,
  parameter int NUM_LEAF_BITS      = 5,
  parameter int NUM_PORT_BITS      = 4,
  parameter int NUM_ADDR_BITS      = 7,
  parameter int NUM_OUT_PORTS      = 4,
  parameter int NUM_BRAM_ADDR_BITS = 7
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]              vld_user2interface,
  output logic [NUM_OUT_PORTS-1:0]              ack_interface2user,
  input  logic                                  cfg_we,
  input  logic [NUM_PORT_BITS-1:0]              cfg_port,
  input  logic [NUM_LEAF_BITS-1:0]              cfg_dest_leaf,
  input  logic [NUM_PORT_BITS-1:0]              cfg_dest_port,
  input  logic                                  credit_vld,
  input  logic [NUM_PORT_BITS-1:0]              credit_port,
  input  logic [NUM_BRAM_ADDR_BITS:0]           credit_amt,
  input  logic                                  bft_ready,
  input  logic                                  resend,
  output logic [PACKET_BITS-1:0]                dout_leaf_interface2bft
);

  import leaf_pkg::*;

  localparam int IDX_W  = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
  localparam int CSUM_W = CREDIT_W + 2;

  packet_t                    out_q;
  logic [NUM_OUT_PORTS-1:0]   enable_q;
  logic [NUM_LEAF_BITS-1:0]   leaf_q   [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0]   port_q   [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0]   addr_q   [NUM_OUT_PORTS];
  logic [CREDIT_W-1:0]        credit_q [NUM_OUT_PORTS];
  logic [CREDIT_W-1:0]        credit_nxt [NUM_OUT_PORTS];
  logic [PAYLOAD_BITS-1:0]    din_word [NUM_OUT_PORTS];

  logic [NUM_OUT_PORTS-1:0]   eligible;
  logic [NUM_OUT_PORTS-1:0]   req;
  logic [NUM_OUT_PORTS-1:0]   grant;
  logic [NUM_OUT_PORTS-1:0]   cfg_hit;
  logic [IDX_W-1:0]           grant_idx;
  logic                       grant_any;
  logic                       slot_free;
  logic [CSUM_W-1:0]          csum;

  function automatic logic [CREDIT_W-1:0] sat_credit(input logic [CSUM_W-1:0] sum);
    if (sum > CSUM_W'(CREDIT_MAX)) return CREDIT_MAX;
    return sum[CREDIT_W-1:0];
  endfunction

  assign slot_free = ~out_q.valid | bft_ready;
  assign grant_any = |grant;

  always_comb begin
    eligible = '0;
    cfg_hit  = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      eligible[i] = vld_user2interface[i] & enable_q[i] & (credit_q[i] != '0) & ~resend;
      cfg_hit[i]  = cfg_we && (cfg_port == NUM_PORT_BITS'(i));
      din_word[i] = din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS];
    end
    req = slot_free ? eligible : '0;
  end

  leaf_rr_arbiter #(
    .NUM_PORTS (NUM_OUT_PORTS),
    .IDX_W     (IDX_W)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .accept    (grant_any),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign ack_interface2user = grant;

  // A grant and a credit return on the same port in one cycle net out before saturation.
  always_comb begin
    csum = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      csum = CSUM_W'(credit_q[i])
           + ((credit_vld && credit_port == NUM_PORT_BITS'(i)) ? CSUM_W'(credit_amt) : '0)
           - CSUM_W'(grant[i]);
      credit_nxt[i] = sat_credit(csum);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q    <= '0;
      enable_q <= '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        leaf_q[i]   <= '0;
        port_q[i]   <= '0;
        addr_q[i]   <= '0;
        credit_q[i] <= CREDIT_MAX;
      end
    end else begin
      // resend freezes the output register so the held packet can be presented again
      if (!resend && slot_free) begin
        out_q <= grant_any ? make_packet(leaf_q[grant_idx], port_q[grant_idx],
                                         addr_q[grant_idx], din_word[grant_idx])
                           : '0;
      end
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        credit_q[i] <= credit_nxt[i];
        if (grant[i]) addr_q[i] <= addr_q[i] + NUM_ADDR_BITS'(1);
        if (cfg_hit[i]) begin
          enable_q[i] <= 1'b1;
          leaf_q[i]   <= cfg_dest_leaf;
          port_q[i]   <= cfg_dest_port;
          addr_q[i]   <= '0;
          credit_q[i] <= CREDIT_MAX;
        end
      end
    end
  end

  assign dout_leaf_interface2bft = resend ? '0 : out_q;

endmodule

// File: tb/tb_leaf_tx_packetizer.sv
// Directed bench for leaf_tx_packetizer: send path, round-robin, credits, backpressure, resend, reset.
module tb_leaf_tx_packetizer;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] din;
  logic [3:0]   vld;
  logic [3:0]   ack;
  logic         cfg_we;
  logic [3:0]   cfg_port;
  logic [4:0]   cfg_dest_leaf;
  logic [3:0]   cfg_dest_port;
  logic         credit_vld;
  logic [3:0]   credit_port;
  logic [7:0]   credit_amt;
  logic         bft_ready;
  logic         resend;
  logic [48:0]  dout;

  int n_assert = 0;
  int n_fail   = 0;

  logic [4:0]  lf [4];
  logic [3:0]  pt [4];
  int          cnt [4];
  int          ex;
  logic [48:0] held;

  always #5 clk = ~clk;

  leaf_tx_packetizer dut (
    .clk                     (clk),
    .reset                   (reset),
    .din_leaf_user2interface (din),
    .vld_user2interface      (vld),
    .ack_interface2user      (ack),
    .cfg_we                  (cfg_we),
    .cfg_port                (cfg_port),
    .cfg_dest_leaf           (cfg_dest_leaf),
    .cfg_dest_port           (cfg_dest_port),
    .credit_vld              (credit_vld),
    .credit_port             (credit_port),
    .credit_amt              (credit_amt),
    .bft_ready               (bft_ready),
    .resend                  (resend),
    .dout_leaf_interface2bft (dout)
  );

  function automatic logic [48:0] mk(input logic [4:0] l, input logic [3:0] p,
                                     input logic [6:0] a, input logic [31:0] d);
    return {1'b1, l, p, a, d};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int p, input logic [4:0] l, input logic [3:0] d);
    cfg_we = 1'b1; cfg_port = 4'(p); cfg_dest_leaf = l; cfg_dest_port = d;
    tick;
    cfg_we = 1'b0;
  endtask

  initial begin
    reset = 1'b1; din = '0; vld = '0; cfg_we = 1'b0; cfg_port = '0;
    cfg_dest_leaf = '0; cfg_dest_port = '0; credit_vld = 1'b0; credit_port = '0;
    credit_amt = '0; bft_ready = 1'b0; resend = 1'b0;
    repeat (2) tick;
    chk("rst_dout", dout, 0);
    vld = 4'hF;
    #1 chk("rst_ack", ack, 0);
    vld = '0; reset = 1'b0;
    tick;
    vld = 4'b0001;
    #1 chk("unconf_ack", ack, 0);
    vld = '0;
    tick;

    // basic single-port send
    lf = '{5'd3, 5'd1, 5'd2, 5'd4};
    pt = '{4'd2, 4'd1, 4'd3, 4'd0};
    cfg(0, lf[0], pt[0]);
    bft_ready = 1'b1; din[31:0] = 32'hDEADBEEF; vld = 4'b0001;
    #1 chk("basic_ack0", ack, 4'b0001);
    tick;
    chk("basic_pkt0", dout, mk(5'd3, 4'd2, 7'd0, 32'hDEADBEEF));
    din[31:0] = 32'h12345678;
    #1 chk("basic_ack1", ack, 4'b0001);
    tick;
    chk("basic_pkt1", dout, mk(5'd3, 4'd2, 7'd1, 32'h12345678));
    vld = '0;
    tick;
    chk("idle_zero", dout, 0);

    // round-robin over all four ports; pointer sits at 1 after the two port-0 grants
    for (int i = 0; i < 4; i++) begin
      cfg(i, lf[i], pt[i]);
      din[i*32 +: 32] = 32'hA0000000 + 32'(i);
      cnt[i] = 0;
    end
    vld = 4'hF; ex = 1;
    for (int n = 0; n < 100; n++) begin
      #1 chk("rr_ack", ack, 64'(1 << ex));
      tick;
      chk("rr_pkt", dout, mk(lf[ex], pt[ex], 7'(cnt[ex]), 32'hA0000000 + 32'(ex)));
      cnt[ex]++;
      ex = (ex + 1) % 4;
    end
    for (int i = 0; i < 4; i++) chk("rr_share", 64'(cnt[i]), 25);
    vld = '0;
    tick;

    // backpressure hold
    din[95:64] = 32'hC0DE0002; vld = 4'b0100; bft_ready = 1'b0;
    #1 chk("bp_first_ack", ack, 4'b0100);
    tick;
    held = mk(lf[2], pt[2], 7'd25, 32'hC0DE0002);
    chk("bp_pkt", dout, held);
    din[95:64] = 32'hC0DE0003;
    for (int n = 0; n < 5; n++) begin
      #1 chk("bp_ack_zero", ack, 0);
      tick;
      chk("bp_hold", dout, held);
    end
    bft_ready = 1'b1;
    #1 chk("bp_release_ack", ack, 4'b0100);
    tick;
    chk("bp_next_pkt", dout, mk(lf[2], pt[2], 7'd26, 32'hC0DE0003));
    vld = '0;
    tick;

    // address wrap on port 1 with a credit return and a resend window mid-stream
    lf[1] = 5'd9; pt[1] = 4'd5;
    cfg(1, lf[1], pt[1]);
    vld = 4'b0010;
    for (int w = 0; w < 130; w++) begin
      din[63:32] = 32'hB0000000 + 32'(w);
      if (w == 50) begin
        credit_vld = 1'b1; credit_port = 4'd1; credit_amt = 8'd10;
      end
      #1 chk("wrap_ack", ack, 4'b0010);
      tick;
      credit_vld = 1'b0;
      chk("wrap_pkt", dout, mk(5'd9, 4'd5, 7'(w % 128), 32'hB0000000 + 32'(w)));
      if (w == 60) begin
        held = mk(5'd9, 4'd5, 7'd60, 32'hB0000000 + 32'd60);
        resend = 1'b1;
        for (int n = 0; n < 3; n++) begin
          #1 chk("rs_dout_zero", dout, 0);
          chk("rs_ack_zero", ack, 0);
          tick;
        end
        resend = 1'b0;
        #1 chk("rs_reappear", dout, held);
      end
    end
    vld = '0;
    tick;

    // credit exhaustion and refill on port 3
    cfg(3, lf[3], pt[3]);
    din[127:96] = 32'hE0000000; vld = 4'b1000;
    for (int k = 0; k < 128; k++) begin
      #1 chk("cr_ack", ack, 4'b1000);
      tick;
    end
    #1 chk("cr_exhausted_ack", ack, 0);
    tick;
    chk("cr_idle", dout, 0);
    credit_vld = 1'b1; credit_port = 4'd3; credit_amt = 8'd16;
    #1 chk("cr_return_cycle_ack", ack, 0);
    tick;
    credit_vld = 1'b0;
    for (int k = 0; k < 16; k++) begin
      #1 chk("cr_refill_ack", ack, 4'b1000);
      tick;
    end
    #1 chk("cr_refill_end", ack, 0);
    credit_vld = 1'b1; credit_amt = 8'd1;
    tick;
    #1 chk("cr_same_cycle_ack", ack, 4'b1000);
    tick;
    credit_vld = 1'b0;
    #1 chk("cr_kept_one", ack, 4'b1000);
    tick;
    #1 chk("cr_drained", ack, 0);
    vld = '0;
    tick;

    // out-of-range config and credit writes must not touch any port
    cfg_we = 1'b1; cfg_port = 4'd7; cfg_dest_leaf = 5'd31; cfg_dest_port = 4'd15;
    credit_vld = 1'b1; credit_port = 4'd7; credit_amt = 8'd5;
    tick;
    cfg_we = 1'b0; credit_vld = 1'b0;
    vld = 4'b1000;
    #1 chk("inv_p3_ack", ack, 0);
    vld = 4'b0001; din[31:0] = 32'hF00D0000;
    #1 chk("inv_p0_ack", ack, 4'b0001);
    tick;
    chk("inv_p0_pkt", dout, mk(5'd3, 4'd2, 7'd25, 32'hF00D0000));

    // asynchronous reset with a packet in flight
    reset = 1'b1;
    #1 chk("rst_mid_dout", dout, 0);
    chk("rst_mid_ack", ack, 0);
    tick;
    reset = 1'b0;
    #1 chk("post_rst_unconf_ack", ack, 0);
    vld = '0;
    tick;
    cfg(0, 5'd7, 4'd6);
    din[31:0] = 32'h5A5A5A5A; vld = 4'b0001;
    #1 chk("post_rst_ack", ack, 4'b0001);
    tick;
    chk("post_rst_pkt", dout, mk(5'd7, 4'd6, 7'd0, 32'h5A5A5A5A));
    vld = '0;
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
